// File: rtl/stream_arbiter.sv
// stream_arbiter
//   Shares one stream sink between N stream producers. Each cycle one valid
//   requester is granted, its word is moved into a one-entry output register
//   and presented downstream together with the index of the source.
//
//   Default arbitration is round-robin starting from a rotating pointer.
//   Defining the macro STREAM_ARB_FIXED_PRIO_EN switches to fixed priority
//   (lowest index wins) and removes the pointer register.
//
// Parameters:
//   N  - number of requesters (2..16)
//   W  - data width per word
//   SW - width of the source index, max(1, $clog2(N))
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   in_valid  - request from source i on bit i
//   in_data   - word of source i at [i*W +: W]
//   in_ready  - one-hot grant (or zero); transfer when in_valid[i] & in_ready[i]
//   out_valid - output register holds a word
//   out_data  - registered word
//   out_src   - index of the source that supplied out_data
//   out_ready - downstream accepts the word when out_valid & out_ready
module stream_arbiter #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = (N > 2) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_src,
  input  logic           out_ready
);

  logic [W-1:0]  words [N];
  logic [SW-1:0] ptr;
  logic [SW-1:0] winner;
  logic [SW-1:0] hi_idx;
  logic [SW-1:0] lo_idx;
  logic          hi_found;
  logic          any_valid;
  logic          load;
  logic          grant;

  logic          out_valid_reg;
  logic [W-1:0]  out_data_reg;
  logic [SW-1:0] out_src_reg;

  // Unpack the flat input bus into one word per source.
  for (genvar gi = 0; gi < N; gi++) begin : g_words
    assign words[gi] = in_data[gi*W +: W];
  end

  // Round-robin search without modular index arithmetic: the lowest valid
  // index at or above ptr wins; if there is none, the search has wrapped and
  // the lowest valid index overall wins. With ptr fixed at 0 this collapses
  // to plain lowest-index priority.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        lo_idx = SW'(i);
        if (i >= int'(ptr)) begin
          hi_found = 1'b1;
          hi_idx   = SW'(i);
        end
      end
    end
    winner = hi_found ? hi_idx : lo_idx;
  end

  assign any_valid = |in_valid;
  assign load      = !out_valid_reg || out_ready;
  assign grant     = load && any_valid;
  assign in_ready  = grant ? (N'(1) << winner) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_src_reg   <= '0;
    end else if (load) begin
      // Simultaneous drain and refill replaces the word in the same edge;
      // a drain with nothing to refill empties the stage but keeps the
      // last data/source for visibility.
      if (any_valid) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= words[winner];
        out_src_reg   <= winner;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

`ifdef STREAM_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [SW-1:0] ptr_reg;

  // The pointer advances only on an accepted transfer, to the slot just
  // after the winner, so a dropped request costs nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (grant) begin
      ptr_reg <= (winner == SW'(N - 1)) ? '0 : winner + 1'b1;
    end
  end

  assign ptr = ptr_reg;
`endif

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_src   = out_src_reg;

endmodule

// File: tb/tb_stream_arbiter.sv
module tb_stream_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           clk;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_src;
  logic           out_ready;

  stream_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  logic                m_valid;
  int                  m_ptr;
  logic [SW+W-1:0]     sb_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_ptr   = 0;
    sb_q.delete();
  endtask

  // One clock cycle: drive inputs on the falling edge, compare against the
  // model just after, then advance the model across the rising edge.
  task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic ordy);
    int              k;
    logic            m_load;
    logic [N-1:0]    exp_ready;
    logic [SW+W-1:0] head;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    #1;
    m_load = !m_valid || ordy;
    k = -1;
    for (int o = 0; o < N; o++) begin
      int c;
      c = (m_ptr + o) % N;
      if (k < 0 && v[c]) k = c;
    end
    exp_ready = '0;
    if (m_load && k >= 0) exp_ready[k] = 1'b1;
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      if (sb_q.size() == 0) begin
        check("sb_nonempty", 32'(0), 32'(1));
      end else begin
        head = sb_q[0];
        check("out_src", 32'(out_src), 32'(head[SW+W-1:W]));
        check("out_data", 32'(out_data), 32'(head[W-1:0]));
        if (ordy) begin
          $display("txn: src=%0d data=%02h", head[SW+W-1:W], head[W-1:0]);
          void'(sb_q.pop_front());
        end
      end
    end
    if (m_load) begin
      if (k >= 0) begin
        sb_q.push_back({SW'(k), d[k*W +: W]});
        m_valid = 1'b1;
`ifndef STREAM_ARB_FIXED_PRIO_EN
        m_ptr = (k + 1) % N;
`endif
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_out_src", 32'(out_src), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(0));

    // Idle, then a single active source granted every cycle.
    cycle(4'b0000, 32'h0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(4'b0100, 32'h00330000, 1'b1);
    cycle(4'b0000, 32'h0, 1'b1);
    cycle(4'b0000, 32'h0, 1'b1);

    // Load 0x5A, hold it under backpressure, then reset mid-FULL.
    cycle(4'b0001, 32'h0000005A, 1'b0);
    cycle(4'b0000, 32'h0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'(0));
    check("arst_out_data", 32'(out_data), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'(0));
    check("mid_rst_out_data", 32'(out_data), 32'(0));
    check("mid_rst_out_src", 32'(out_src), 32'(0));
    check("mid_rst_in_ready", 32'(in_ready), 32'(0));

    // Fairness: all sources valid for 8 cycles.
    for (int i = 0; i < 8; i++) cycle(4'b1111, 32'h13121110, 1'b1);

    // Backpressure: FULL with source 1, then 5 stalled cycles, then release.
    cycle(4'b0010, 32'h13121110, 1'b1);
    for (int i = 0; i < 5; i++) cycle(4'b1111, 32'h13121110, 1'b0);
    cycle(4'b1111, 32'h13121110, 1'b1);

    // Drain without refill, then sources 3 and 0 compete.
    cycle(4'b0000, 32'h0, 1'b1);
    cycle(4'b0000, 32'h0, 1'b1);
    cycle(4'b1001, 32'hA0B0C0D0, 1'b1);
    cycle(4'b0000, 32'h0, 1'b1);

    // All valid for 6 cycles, then source 0 drops out.
    for (int i = 0; i < 6; i++) cycle(4'b1111, 32'h44332211, 1'b1);
    cycle(4'b1110, 32'h44332211, 1'b1);
    cycle(4'b0000, 32'h0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      cycle(4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) != 0));
    end
    cycle(4'b0000, 32'h0, 1'b1);
    cycle(4'b0000, 32'h0, 1'b1);
    check("sb_drained", 32'(sb_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
